// File: rtl/wb_arbiter_if.sv
// Result-source bus for the writeback arbiter: pipeline and long-latency channels.
// The arbiter connects through the slave modport and the producers through the master modport.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              pipe_valid;
  logic              pipe_ready;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              lat_valid;
  logic              lat_ready;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  modport master (
    output pipe_valid, pipe_addr, pipe_data, lat_valid, lat_addr, lat_data,
    input  pipe_ready, lat_ready
  );

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data, lat_valid, lat_addr, lat_data,
    output pipe_ready, lat_ready
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline results with FIFO-buffered long-latency results into the
// register-file write port and tracks pending long-latency destinations. WB_BYPASS_EN adds byp_* outputs.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_arbiter_if.slave          bus,
  input  logic                 issue_set,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 reg_we,
  output logic [ADDR_W-1:0]    reg_waddr,
  output logic [DATA_W-1:0]    reg_wdata
`ifdef WB_BYPASS_EN
  ,
  output logic                 byp_valid,
  output logic [ADDR_W-1:0]    byp_addr,
  output logic [DATA_W-1:0]    byp_data
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 2**ADDR_W;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

  logic              empty_s, full_s, starve_hit_s;
  logic              fifo_win_s, pipe_win_s, win_valid_s, push_s;
  logic [ADDR_W-1:0] head_addr_s, win_addr_s;
  logic [DATA_W-1:0] head_data_s, win_data_s;

  assign empty_s      = (count_q == {CNT_W{1'b0}});
  assign full_s       = (count_q == DEPTH_C);
  assign head_addr_s  = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
  assign head_data_s  = mem_q[rd_ptr_q][DATA_W-1:0];
  // Both readies come from state only, so neither depends on its own source's valid.
  assign starve_hit_s = !empty_s && (starve_q == LIMIT_C);
  assign fifo_win_s   = !empty_s && (starve_hit_s || !bus.pipe_valid);
  assign pipe_win_s   = bus.pipe_valid && !starve_hit_s;
  assign win_valid_s  = fifo_win_s || pipe_win_s;
  assign push_s       = bus.lat_valid && !full_s;

  assign bus.pipe_ready = !starve_hit_s;
  assign bus.lat_ready  = !full_s;
  assign busy           = busy_q;
  assign reg_we         = reg_we_q;
  assign reg_waddr      = reg_waddr_q;
  assign reg_wdata      = reg_wdata_q;

  // Winner select.
  always_comb begin
    win_addr_s = {ADDR_W{1'b0}};
    win_data_s = {DATA_W{1'b0}};
    if (fifo_win_s) begin
      win_addr_s = head_addr_s;
      win_data_s = head_data_s;
    end else begin
      win_addr_s = bus.pipe_addr;
      win_data_s = bus.pipe_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = win_valid_s && (win_addr_s != {ADDR_W{1'b0}});
  assign byp_addr  = win_addr_s;
  assign byp_data  = win_data_s;
`endif

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {bus.lat_addr, bus.lat_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (fifo_win_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, fifo_win_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: only advances while a waiting head loses to the pipeline.
  always_comb begin
    starve_d = starve_q;
    if (empty_s || fifo_win_s) begin
      starve_d = {STV_W{1'b0}};
    end else begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Scoreboard: a new issue to the same register outranks the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (fifo_win_s) begin
      busy_d[head_addr_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_set && (issue_addr != {ADDR_W{1'b0}})) begin
      busy_d[issue_addr] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Register-file write stage; address 0 is consumed but never written.
  always_comb begin
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    if (win_valid_s) begin
      reg_we_d    = (win_addr_s != {ADDR_W{1'b0}});
      reg_waddr_d = win_addr_s;
      reg_wdata_d = win_data_s;
    end else begin
      reg_we_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      starve_q    <= {STV_W{1'b0}};
      busy_q      <= {NREG{1'b0}};
      reg_we_q    <= 1'b0;
      reg_waddr_q <= {ADDR_W{1'b0}};
      reg_wdata_q <= {DATA_W{1'b0}};
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      busy_q      <= busy_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a reference model queues expected writes at stimulus time
// and they are compared against the registered write port one cycle later.
module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_set;
  logic [AW-1:0] issue_addr;
  logic [31:0]   busy;
  logic          reg_we;
  logic [AW-1:0] reg_waddr;
  logic [DW-1:0] reg_wdata;
`ifdef WB_BYPASS_EN
  logic          byp_valid;
  logic [AW-1:0] byp_addr;
  logic [DW-1:0] byp_data;
`endif

  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .issue_set  (issue_set),
    .issue_addr (issue_addr),
    .busy       (busy),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid  (byp_valid),
    .byp_addr   (byp_addr),
    .byp_data   (byp_data)
`endif
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t              exp_q[$];
  logic [AW+DW-1:0] fifo_m[$];
  int               starve_m;
  logic [31:0]      busy_m;
  logic [AW-1:0]    last_a;
  logic [DW-1:0]    last_d;
  int               checks = 0;
  int               errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic is, input logic [AW-1:0] ia);
    bus.pipe_valid = pv; bus.pipe_addr = pa; bus.pipe_data = pd;
    bus.lat_valid  = lv; bus.lat_addr  = la; bus.lat_data  = ld;
    issue_set = is; issue_addr = ia;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // One clock: predict from the model, check readies, then compare the registered write.
  task automatic step();
    logic ne, fwin, pwin, exp_pr, exp_lr, has;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    wr_t e;
    #1;
    ne     = (fifo_m.size() != 0);
    exp_pr = !(ne && starve_m == LIMIT);
    exp_lr = (fifo_m.size() < DEPTH);
    fwin   = ne && (starve_m == LIMIT || !bus.pipe_valid);
    pwin   = bus.pipe_valid && exp_pr;
    check_eq("pipe_ready", {63'd0, bus.pipe_ready}, {63'd0, exp_pr});
    check_eq("lat_ready", {63'd0, bus.lat_ready}, {63'd0, exp_lr});
    wa = 5'd0;
    wd = 32'd0;
    if (fwin) begin
      {wa, wd} = fifo_m.pop_front();
      busy_m[wa] = 1'b0;
      starve_m = 0;
    end else if (pwin) begin
      wa = bus.pipe_addr;
      wd = bus.pipe_data;
      starve_m = ne ? starve_m + 1 : 0;
    end else begin
      starve_m = 0;
    end
    has = fwin || pwin;
`ifdef WB_BYPASS_EN
    check_eq("byp_valid", {63'd0, byp_valid}, {63'd0, has && wa != 5'd0});
    if (has) check_eq("byp_data", {32'd0, byp_data}, {32'd0, wd});
`endif
    if (has) begin
      last_a = wa;
      last_d = wd;
    end
    e.we = has && (wa != 5'd0);
    e.a  = last_a;
    e.d  = last_d;
    exp_q.push_back(e);
    if (bus.lat_valid && exp_lr) fifo_m.push_back({bus.lat_addr, bus.lat_data});
    if (issue_set && issue_addr != 5'd0) busy_m[issue_addr] = 1'b1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("reg_we", {63'd0, reg_we}, {63'd0, e.we});
    check_eq("reg_waddr", {59'd0, reg_waddr}, {59'd0, e.a});
    check_eq("reg_wdata", {32'd0, reg_wdata}, {32'd0, e.d});
    check_eq("busy", {32'd0, busy}, {32'd0, busy_m});
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #1;
    check_eq("rst_reg_we", {63'd0, reg_we}, 64'd0);
    check_eq("rst_waddr", {59'd0, reg_waddr}, 64'd0);
    check_eq("rst_wdata", {32'd0, reg_wdata}, 64'd0);
    check_eq("rst_busy", {32'd0, busy}, 64'd0);
    check_eq("rst_lat_ready", {63'd0, bus.lat_ready}, 64'd1);
    fifo_m.delete();
    exp_q.delete();
    starve_m = 0;
    busy_m = 32'd0;
    last_a = 5'd0;
    last_d = 32'd0;
    @(posedge clk);
    #1;
    check_eq("rst_hold_we", {63'd0, reg_we}, 64'd0);
    check_eq("rst_hold_busy", {32'd0, busy}, 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    do_reset();

    // Single pipeline write.
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    check_eq("pipe_w3_data", {32'd0, reg_wdata}, 64'h11);
    idle(); step();

    // Long-latency write clears its busy bit as it retires.
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    step();
    check_eq("busy7_set", {63'd0, busy[7]}, 64'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA, 1'b0, 5'd0);
    step();
    idle(); step();
    check_eq("lat7_we", {63'd0, reg_we}, 64'd1);
    check_eq("lat7_busy_clr", {63'd0, busy[7]}, 64'd0);

    // Starvation: FIFO head loses three times, then is forced through.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i + 32'h100), i == 0, 5'd12, 32'hBB, 1'b0, 5'd0);
      step();
    end
    check_eq("starve_win_addr", {59'd0, reg_waddr}, 64'd12);
    check_eq("starve_win_data", {32'd0, reg_wdata}, 64'hBB);

    // Two pushes while the pipeline saturates: FIFO fills and later drains.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 5'd20, 32'(i), i < 2, 5'(21 + i), 32'(32'h200 + i), 1'b0, 5'd0);
      step();
    end
    idle(); step();

    // Issue and retire of the same register in one cycle: set wins.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step();
    check_eq("busy9_set_wins", {63'd0, busy[9]}, 64'd1);
    check_eq("lat9_data", {32'd0, reg_wdata}, 64'h99);

    // Pipeline write to register 0.
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    check_eq("addr0_we", {63'd0, reg_we}, 64'd0);

    // Mid-stream reset with a full FIFO and a pending busy bit.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55, 1'b1, 5'd5);
    step();
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
    step();
    check_eq("pre_rst_full", {63'd0, bus.lat_ready}, 64'd0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), 5'($urandom));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
